// File: rtl/picorv32_axi_pkg.sv
// rtl/picorv32_axi_pkg.sv - shared constants for the picorv32 AXI4-Lite bridge
package picorv32_axi_pkg;

  localparam logic [2:0] PROT_INSN = 3'b100;
  localparam logic [2:0] PROT_DATA = 3'b000;

  localparam int TRACE_W         = 36;
  localparam int TRACE_BIT_WRITE = 35;
  localparam int TRACE_BIT_INSN  = 34;

  function automatic logic [TRACE_W-1:0] trace_word(input logic        is_write,
                                                    input logic        instr,
                                                    input logic [31:0] data);
    logic [TRACE_W-1:0] w;
    w                  = '0;
    w[TRACE_BIT_WRITE] = is_write;
    w[TRACE_BIT_INSN]  = instr;
    w[31:0]            = data;
    return w;
  endfunction

endpackage

// File: rtl/picorv32_axi_bridge_if.sv
// rtl/picorv32_axi_bridge_if.sv - AXI4-Lite bus bundle with master/slave views
interface picorv32_axi_bridge_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awprot;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  logic        bvalid;
  logic        bready;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arprot;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, arready, rvalid, rdata
  );

endinterface

// File: rtl/picorv32_axi_bridge_trace.sv
// rtl/picorv32_axi_bridge_trace.sv - registers one trace word per completed transfer
module picorv32_axi_bridge_trace
  import picorv32_axi_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_ready,
  input  logic               is_write,
  input  logic               mem_instr,
  input  logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               trace_valid,
  output logic [TRACE_W-1:0] trace_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_data  <= '0;
    end else begin
      trace_valid <= mem_ready;
      if (mem_ready)
        trace_data <= trace_word(is_write, mem_instr, is_write ? mem_wdata : mem_rdata);
    end
  end

endmodule

// File: rtl/picorv32_axi_bridge.sv
// rtl/picorv32_axi_bridge.sv - native memory port to AXI4-Lite master; trace via PICORV32_AXI_BRIDGE_TRACE_EN
module picorv32_axi_bridge
  import picorv32_axi_pkg::*;
#(
  parameter logic [2:0] INSN_PROT = PROT_INSN,
  parameter logic [2:0] DATA_PROT = PROT_DATA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_instr,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  picorv32_axi_bridge_if.master axi,
  output logic                  trace_valid,
  output logic [TRACE_W-1:0]    trace_data
);

  logic is_write;
  logic is_read;
  logic ack_aw;
  logic ack_w;
  logic ack_ar;

  assign is_write = mem_valid && (mem_wstrb != 4'b0000);
  assign is_read  = mem_valid && (mem_wstrb == 4'b0000);

  // Flags remember which channels already handshook so no valid is re-raised
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_aw <= 1'b0;
      ack_w  <= 1'b0;
      ack_ar <= 1'b0;
    end else if (!mem_valid || mem_ready) begin
      ack_aw <= 1'b0;
      ack_w  <= 1'b0;
      ack_ar <= 1'b0;
    end else begin
      if (axi.awvalid && axi.awready) ack_aw <= 1'b1;
      if (axi.wvalid  && axi.wready)  ack_w  <= 1'b1;
      if (axi.arvalid && axi.arready) ack_ar <= 1'b1;
    end
  end

  assign axi.awvalid = !reset && is_write && !ack_aw;
  assign axi.wvalid  = !reset && is_write && !ack_w;
  assign axi.arvalid = !reset && is_read  && !ack_ar;
  assign axi.bready  = !reset && mem_valid;
  assign axi.rready  = !reset && mem_valid;

  assign axi.awaddr  = mem_addr;
  assign axi.araddr  = mem_addr;
  assign axi.wdata   = mem_wdata;
  assign axi.wstrb   = mem_wstrb;
  assign axi.arprot  = mem_instr ? INSN_PROT : DATA_PROT;
  assign axi.awprot  = DATA_PROT;

  assign mem_ready   = !reset && (axi.bvalid || axi.rvalid);
  assign mem_rdata   = axi.rdata;

`ifdef PICORV32_AXI_BRIDGE_TRACE_EN
  picorv32_axi_bridge_trace u_trace (
    .clk         (clk),
    .reset       (reset),
    .mem_ready   (mem_ready),
    .is_write    (is_write),
    .mem_instr   (mem_instr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .trace_valid (trace_valid),
    .trace_data  (trace_data)
  );
`else
  assign trace_valid = 1'b0;
  assign trace_data  = '0;
`endif

endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// tb/tb_picorv32_axi_bridge.sv - directed per-cycle vector bench for picorv32_axi_bridge
module tb_picorv32_axi_bridge;
  import picorv32_axi_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               mem_valid, mem_instr, mem_ready;
  logic [31:0]        mem_addr, mem_wdata, mem_rdata;
  logic [3:0]         mem_wstrb;
  logic               trace_valid;
  logic [TRACE_W-1:0] trace_data;

  picorv32_axi_bridge_if axi ();

  picorv32_axi_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .mem_valid   (mem_valid),
    .mem_instr   (mem_instr),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .axi         (axi),
    .trace_valid (trace_valid),
    .trace_data  (trace_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        instr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        awr;
    logic        wr;
    logic        bv;
    logic        arr;
    logic        rv;
    logic [31:0] rdata;
    logic        e_aw;
    logic        e_w;
    logic        e_ar;
    logic        e_ready;
    logic [2:0]  e_arprot;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t r);
    mem_valid   = r.v;
    mem_instr   = r.instr;
    mem_wstrb   = r.wstrb;
    mem_addr    = r.addr;
    mem_wdata   = r.wdata;
    axi.awready = r.awr;
    axi.wready  = r.wr;
    axi.bvalid  = r.bv;
    axi.arready = r.arr;
    axi.rvalid  = r.rv;
    axi.rdata   = r.rdata;
  endtask

  function automatic vec_t idle_row();
    vec_t r;
    r = '{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
          1'b0, 1'b0, 1'b0, 1'b0, 3'b000};
    return r;
  endfunction

  vec_t r;

  initial begin
    // fetch at 0x10, arready after two waits, then rvalid
    vecs.push_back('{1,1,4'h0,32'h10,0, 0,0,0,0,0,32'h0,        0,0,1,0,3'b100});
    vecs.push_back('{1,1,4'h0,32'h10,0, 0,0,0,0,0,32'h0,        0,0,1,0,3'b100});
    vecs.push_back('{1,1,4'h0,32'h10,0, 0,0,0,1,0,32'h0,        0,0,1,0,3'b100});
    vecs.push_back('{1,1,4'h0,32'h10,0, 0,0,0,0,1,32'h13,       0,0,0,1,3'b100});
    vecs.push_back(idle_row());
    // store, AW accepted before W
    vecs.push_back('{1,0,4'hF,32'h1000_0000,32'h41, 1,0,0,0,0,0, 1,1,0,0,3'b000});
    vecs.push_back('{1,0,4'hF,32'h1000_0000,32'h41, 0,0,0,0,0,0, 0,1,0,0,3'b000});
    vecs.push_back('{1,0,4'hF,32'h1000_0000,32'h41, 0,1,0,0,0,0, 0,1,0,0,3'b000});
    vecs.push_back('{1,0,4'hF,32'h1000_0000,32'h41, 0,0,1,0,0,0, 0,0,0,1,3'b000});
    vecs.push_back(idle_row());
    // store, simultaneous AW/W handshake
    vecs.push_back('{1,0,4'hF,32'h2000_0000,32'd123456789, 1,1,0,0,0,0, 1,1,0,0,3'b000});
    vecs.push_back('{1,0,4'hF,32'h2000_0000,32'd123456789, 0,0,0,0,0,0, 0,0,0,0,3'b000});
    vecs.push_back('{1,0,4'hF,32'h2000_0000,32'd123456789, 0,0,1,0,0,0, 0,0,0,1,3'b000});
    vecs.push_back(idle_row());
    // byte store, W accepted before AW
    vecs.push_back('{1,0,4'b0100,32'h102,32'h00AB_0000, 0,0,0,0,0,0, 1,1,0,0,3'b000});
    vecs.push_back('{1,0,4'b0100,32'h102,32'h00AB_0000, 0,1,0,0,0,0, 1,1,0,0,3'b000});
    vecs.push_back('{1,0,4'b0100,32'h102,32'h00AB_0000, 1,0,0,0,0,0, 1,0,0,0,3'b000});
    vecs.push_back('{1,0,4'b0100,32'h102,32'h00AB_0000, 0,0,1,0,0,0, 0,0,0,1,3'b000});
    vecs.push_back(idle_row());
    // mem_valid drops after the AR handshake; next read starts fresh
    vecs.push_back('{1,0,4'h0,32'h200,0, 0,0,0,1,0,32'h0,       0,0,1,0,3'b000});
    vecs.push_back(idle_row());
    vecs.push_back('{1,0,4'h0,32'h300,0, 0,0,0,0,0,32'h0,       0,0,1,0,3'b000});
    vecs.push_back('{1,0,4'h0,32'h300,0, 0,0,0,1,0,32'h0,       0,0,1,0,3'b000});
    vecs.push_back('{1,0,4'h0,32'h300,0, 0,0,0,0,1,32'h5555_AAAA, 0,0,0,1,3'b000});
    vecs.push_back(idle_row());
    // stray bvalid during a read still drives mem_ready
    vecs.push_back('{1,0,4'h0,32'h400,0, 0,0,1,0,0,32'h0,       0,0,1,1,3'b000});
    vecs.push_back(idle_row());

    drive(idle_row());
    reset = 1'b1;
    @(negedge clk);
    // reset must force valids and mem_ready low even with a live request and responses
    mem_valid  = 1'b1;
    mem_wstrb  = 4'hF;
    axi.bvalid = 1'b1;
    #2;
    chk("reset_ctrl", {58'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, mem_ready}, 64'd0);
    chk("reset_trace", {63'd0, trace_valid}, 64'd0);
    @(negedge clk);
    drive(idle_row());
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("ctrl[%0d]", i),
          {58'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, mem_ready},
          {58'd0, vecs[i].e_aw, vecs[i].e_w, vecs[i].e_ar, vecs[i].v, vecs[i].v, vecs[i].e_ready});
      chk($sformatf("rdata[%0d]", i), {32'd0, mem_rdata}, {32'd0, vecs[i].rdata});
      if (vecs[i].v) begin
        chk($sformatf("araddr[%0d]", i), {32'd0, axi.araddr}, {32'd0, vecs[i].addr});
        chk($sformatf("awaddr[%0d]", i), {32'd0, axi.awaddr}, {32'd0, vecs[i].addr});
        chk($sformatf("wdata[%0d]",  i), {32'd0, axi.wdata},  {32'd0, vecs[i].wdata});
        chk($sformatf("wstrb[%0d]",  i), {60'd0, axi.wstrb},  {60'd0, vecs[i].wstrb});
        chk($sformatf("arprot[%0d]", i), {61'd0, axi.arprot}, {61'd0, vecs[i].e_arprot});
        chk($sformatf("awprot[%0d]", i), {61'd0, axi.awprot}, 64'd0);
      end
    end

    // reset asserted after the AR handshake, before rvalid
    @(negedge clk);
    r = '{1,0,4'h0,32'h40,0, 0,0,0,1,0,32'h0, 0,0,1,0,3'b000};
    drive(r);
    @(negedge clk);
    axi.arready = 1'b0;
    #2;
    chk("mid_read_ar_dropped", {63'd0, axi.arvalid}, 64'd0);
    reset = 1'b1;
    axi.rvalid = 1'b1;
    #1;
    chk("mid_read_reset_ctrl", {58'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, mem_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    axi.rvalid = 1'b0;
    #2;
    chk("post_reset_arvalid", {63'd0, axi.arvalid}, 64'd1);
    chk("post_reset_rready", {63'd0, axi.rready}, 64'd1);
    @(negedge clk);
    drive(idle_row());

    // load returning 0xDEADBEEF for the trace register
    @(negedge clk);
    r = '{1,0,4'h0,32'h80,0, 0,0,0,1,0,32'h0, 0,0,1,0,3'b000};
    drive(r);
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 32'hDEAD_BEEF;
    #2;
    chk("trace_load_ready", {63'd0, mem_ready}, 64'd1);
    chk("trace_before", {63'd0, trace_valid}, 64'd0);
    @(negedge clk);
    drive(idle_row());
    #2;
`ifdef PICORV32_AXI_BRIDGE_TRACE_EN
    chk("trace_valid_pulse", {63'd0, trace_valid}, 64'd1);
    chk("trace_data", {28'd0, trace_data}, {28'd0, 36'h0_DEAD_BEEF});
`else
    chk("trace_valid_off", {63'd0, trace_valid}, 64'd0);
    chk("trace_data_off", {28'd0, trace_data}, 64'd0);
`endif
    @(negedge clk);
    #2;
    chk("trace_valid_end", {63'd0, trace_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
